// File: rtl/rocket_launch_manager.sv
`default_nettype none
// ============================================================================
// Module   : rocket_launch_manager
// Purpose  : Allocator/launcher for a bank of single-rocket motion
//            controllers. Captures fire requests from the shooter, launches
//            the lowest free rocket slot, drives the shared spawn coordinates
//            and launch speed, retires slots on border/hit reports and
//            enforces a frame-based cooldown between launches.
// Ports    : clk           - system clock
//            reset         - asynchronous, active-high reset
//            startOfFrame  - one-clk pulse at frame start
//            fireRequest   - shooter fire level (rising edge = one shot)
//            shooterX/Y    - shooter top-left position (signed 11-bit)
//            reachedBorder - per-slot border report
//            rocketHit     - per-slot collision report
//            isActive      - per-slot active flag
//            initialX/Y    - spawn coordinates (shared by all slots)
//            initialSpeed  - launch speed (shared by all slots)
//            fireAccepted  - one-clk pulse on each launch
//            activeCount   - number of set isActive bits
// Revision : 1.0 - initial release
// ============================================================================
module rocket_launch_manager #(
    parameter int NUM_ROCKETS     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ROCKET_SPEED    = -256,
    parameter int X_OFFSET        = 14,
    parameter int Y_OFFSET        = -12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    fireRequest,
    input  logic signed [10:0]      shooterX,
    input  logic signed [10:0]      shooterY,
    input  logic [NUM_ROCKETS-1:0]  reachedBorder,
    input  logic [NUM_ROCKETS-1:0]  rocketHit,
    output logic [NUM_ROCKETS-1:0]  isActive,
    output logic signed [10:0]      initialX,
    output logic signed [10:0]      initialY,
    output logic signed [10:0]      initialSpeed,
    output logic                    fireAccepted,
    output logic [3:0]              activeCount
);

    localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    localparam logic signed [10:0] c_x_offset = 11'(X_OFFSET);
    localparam logic signed [10:0] c_y_offset = 11'(Y_OFFSET);
    localparam logic signed [10:0] c_speed    = 11'(ROCKET_SPEED);
    localparam logic [CNT_W-1:0]   c_cool_load = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_READY    = 1'b0,
        S_COOLDOWN = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_fire_d;
    logic                    r_pending;
    logic [CNT_W-1:0]        r_cool_cnt;
    // Slot launched at the previous edge, and the one before that. A slot
    // flagged here ignores retire reports: its controller is still showing
    // the position of the previous flight.
    logic [NUM_ROCKETS-1:0]  r_guard0;
    logic [NUM_ROCKETS-1:0]  r_guard1;

    logic                    w_fire_edge;
    logic                    w_launch;
    logic [NUM_ROCKETS-1:0]  w_free;
    logic [NUM_ROCKETS-1:0]  w_lowest_free;
    logic [NUM_ROCKETS-1:0]  w_launch_oh;
    logic [NUM_ROCKETS-1:0]  w_retire;
    logic [NUM_ROCKETS-1:0]  w_next_active;
    logic [3:0]              w_next_count;

    assign w_fire_edge = fireRequest & ~r_fire_d;

    // Free means inactive at the start of this cycle, so a slot retiring now
    // spends at least one cycle low before it can be relaunched.
    assign w_free   = ~isActive;
    assign w_launch = (r_state == S_READY) && r_pending && (|w_free);

    // Lowest-index free slot, one-hot.
    always_comb begin
        w_lowest_free = '0;
        for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_lowest_free    = '0;
                w_lowest_free[i] = 1'b1;
            end
        end
    end

    assign w_launch_oh   = w_launch ? w_lowest_free : '0;
    assign w_retire      = isActive & (reachedBorder | rocketHit) & ~(r_guard0 | r_guard1);
    assign w_next_active = (isActive & ~w_retire) | w_launch_oh;

    always_comb begin
        w_next_count = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            w_next_count = w_next_count + {3'b000, w_next_active[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_READY;
            r_fire_d     <= 1'b0;
            r_pending    <= 1'b0;
            r_cool_cnt   <= '0;
            r_guard0     <= '0;
            r_guard1     <= '0;
            isActive     <= '0;
            initialX     <= '0;
            initialY     <= '0;
            initialSpeed <= '0;
            fireAccepted <= 1'b0;
            activeCount  <= '0;
        end else begin
            r_fire_d     <= fireRequest;
            r_guard0     <= w_launch_oh;
            r_guard1     <= r_guard0;
            isActive     <= w_next_active;
            activeCount  <= w_next_count;
            fireAccepted <= w_launch;

            // Only one shot is ever queued; an edge arriving while a shot is
            // pending (including the launch cycle itself) is absorbed.
            if (w_launch) begin
                r_pending    <= 1'b0;
                initialX     <= shooterX + c_x_offset;
                initialY     <= shooterY + c_y_offset;
                initialSpeed <= c_speed;
            end else if (w_fire_edge) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_READY: begin
                    if (w_launch && (COOLDOWN_FRAMES != 0)) begin
                        r_state    <= S_COOLDOWN;
                        r_cool_cnt <= c_cool_load;
                    end
                end
                S_COOLDOWN: begin
                    if (r_cool_cnt == '0) begin
                        r_state <= S_READY;
                    end else if (startOfFrame) begin
                        r_cool_cnt <= r_cool_cnt - c_cnt_one;
                    end
                end
                default: r_state <= S_READY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rocket_launch_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_rocket_launch_manager
// Purpose  : Directed self-checking bench for rocket_launch_manager with the
//            default parameters (4 slots, 8-frame cooldown).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rocket_launch_manager;

    logic               clk;
    logic               reset;
    logic               startOfFrame;
    logic               fireRequest;
    logic signed [10:0] shooterX;
    logic signed [10:0] shooterY;
    logic [3:0]         reachedBorder;
    logic [3:0]         rocketHit;
    logic [3:0]         isActive;
    logic signed [10:0] initialX;
    logic signed [10:0] initialY;
    logic signed [10:0] initialSpeed;
    logic               fireAccepted;
    logic [3:0]         activeCount;

    int checks = 0;
    int errors = 0;

    rocket_launch_manager #(
        .NUM_ROCKETS     (4),
        .COOLDOWN_FRAMES (8),
        .ROCKET_SPEED    (-256),
        .X_OFFSET        (14),
        .Y_OFFSET        (-12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .fireRequest   (fireRequest),
        .shooterX      (shooterX),
        .shooterY      (shooterY),
        .reachedBorder (reachedBorder),
        .rocketHit     (rocketHit),
        .isActive      (isActive),
        .initialX      (initialX),
        .initialY      (initialY),
        .initialSpeed  (initialSpeed),
        .fireAccepted  (fireAccepted),
        .activeCount   (activeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    // Edge captured at the first tick, launch at the second.
    task automatic fire_pulse();
        fireRequest = 1'b1;
        tick();
        fireRequest = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        startOfFrame  = 1'b0;
        fireRequest   = 1'b0;
        shooterX      = 11'sd300;
        shooterY      = 11'sd440;
        reachedBorder = 4'b0000;
        rocketHit     = 4'b0000;
        tick();
        tick();
        check("rst_isActive", isActive, 0);
        check("rst_initialX", initialX, 0);
        check("rst_initialY", initialY, 0);
        check("rst_speed", initialSpeed, 0);
        check("rst_fireAcc", fireAccepted, 0);
        check("rst_count", activeCount, 0);
        reset = 1'b0;
        tick();

        // First launch: two clocks after the fire edge.
        fireRequest = 1'b1;
        tick();
        check("l1_pending_isActive", isActive, 0);
        check("l1_pending_fireAcc", fireAccepted, 0);
        tick();
        check("l1_isActive", isActive, 4'b0001);
        check("l1_initialX", initialX, 314);
        check("l1_initialY", initialY, 428);
        check("l1_speed", initialSpeed, -256);
        check("l1_fireAcc", fireAccepted, 1);
        check("l1_count", activeCount, 1);
        fireRequest = 1'b0;   // level held for two clocks never re-fires
        tick();
        check("l1_fireAcc_pulse", fireAccepted, 0);

        // Two edges during cooldown queue a single shot.
        fire_pulse();
        fire_pulse();
        frames(7);
        check("cd_7frames", isActive, 4'b0001);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("cd_8th_frame", isActive, 4'b0001);
        tick();
        check("cd_to_ready", isActive, 4'b0001);
        tick();
        check("l2_isActive", isActive, 4'b0011);
        check("l2_fireAcc", fireAccepted, 1);
        check("l2_count", activeCount, 2);
        frames(8);
        tick();
        tick();
        check("l2_single_shot", isActive, 4'b0011);

        // Fill all slots, then queue a fifth shot.
        fire_pulse();
        check("l3_isActive", isActive, 4'b0111);
        frames(8);
        fire_pulse();
        check("l4_isActive", isActive, 4'b1111);
        check("l4_count", activeCount, 4);
        frames(8);
        fire_pulse();
        tick();
        check("full_held", isActive, 4'b1111);
        check("full_no_accept", fireAccepted, 0);
        rocketHit = 4'b0100;
        tick();
        rocketHit = 4'b0000;
        check("hit2_isActive", isActive, 4'b1011);
        check("hit2_count", activeCount, 3);
        tick();
        check("relaunch2_isActive", isActive, 4'b1111);
        check("relaunch2_fireAcc", fireAccepted, 1);
        frames(8);

        // Stale border report is ignored for two cycles after launch.
        reachedBorder = 4'b0001;
        tick();
        reachedBorder = 4'b0000;
        check("border0_retire", isActive, 4'b1110);
        fire_pulse();
        check("relaunch0_isActive", isActive, 4'b1111);
        reachedBorder = 4'b0001;
        tick();
        check("guard_cycle1", isActive, 4'b1111);
        tick();
        check("guard_cycle2", isActive, 4'b1111);
        tick();
        check("guard_expired", isActive, 4'b1110);
        reachedBorder = 4'b0000;

        // Multiple retirements in one cycle.
        rocketHit = 4'b1110;
        tick();
        rocketHit = 4'b0000;
        check("multi_retire", isActive, 4'b0000);
        check("multi_retire_count", activeCount, 0);
        frames(8);
        fire_pulse();
        check("l0_only", isActive, 4'b0001);
        frames(8);

        // Launch on slot 1 coincident with slot 0 retiring.
        fireRequest = 1'b1;
        tick();
        fireRequest   = 1'b0;
        reachedBorder = 4'b0001;
        tick();
        reachedBorder = 4'b0000;
        check("swap_isActive", isActive, 4'b0010);
        check("swap_count", activeCount, 1);
        check("swap_fireAcc", fireAccepted, 1);

        // Three active rockets in cooldown, then asynchronous reset.
        frames(8);
        fire_pulse();
        frames(8);
        fire_pulse();
        check("pre_rst_isActive", isActive, 4'b0111);
        reset = 1'b1;
        #1;
        check("async_rst_isActive", isActive, 0);
        check("async_rst_count", activeCount, 0);
        check("async_rst_initialX", initialX, 0);
        check("async_rst_initialY", initialY, 0);
        check("async_rst_speed", initialSpeed, 0);
        tick();
        reset = 1'b0;

        // Post-reset launch needs no cooldown; spawn coordinates wrap.
        shooterX = 11'sd1020;
        shooterY = -11'sd1020;
        fire_pulse();
        check("post_rst_isActive", isActive, 4'b0001);
        check("post_rst_fireAcc", fireAccepted, 1);
        check("wrap_initialX", initialX, -1014);
        check("wrap_initialY", initialY, 1016);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
